// File: rtl/bird_pkg.sv
// Shared types and constants for the bird object stage.
//   bird_state_e : life-cycle state of one bird
//   coord_t      : signed screen coordinate
//   colours      : transparent key, hit tint and bitmap palette
package bird_pkg;

  localparam int COORD_W = 12;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    IDLE,
    FLYING,
    HIT,
    FALLING,
    RESPAWN
  } bird_state_e;

  localparam logic [7:0] TRANSPARENT_COLOR = 8'hFF;
  localparam logic [7:0] HIT_COLOR         = 8'hE0;

  // Bitmap palette (RRRGGGBB)
  localparam logic [7:0] BODY_COLOR    = 8'hFC;
  localparam logic [7:0] WING_DN_COLOR = 8'h03;
  localparam logic [7:0] WING_UP_COLOR = 8'h1C;
  localparam logic [7:0] EYE_COLOR     = 8'h00;

  // Unsigned scan coordinate -> signed coordinate (zero-extended)
  function automatic coord_t to_coord(input logic [COORD_W-2:0] p);
    return coord_t'({1'b0, p});
  endfunction

endpackage

// File: rtl/bird_bitmap.sv
// Combinational bird sprite ROM, 2 frames x OBJ_H x OBJ_W x 8 bits.
// The image is described procedurally so it scales with OBJ_W/OBJ_H:
//   - top and bottom OBJ_H/8 rows transparent
//   - small transparent notch in the top-left corner (beak gap)
//   - wing block whose colour changes between the two flap frames
//   - single eye pixel, everything else body colour
// Ports:
//   frame  : animation frame select
//   off_y  : row inside the sprite
//   off_x  : column inside the sprite
//   color  : RRRGGGBB colour, TRANSPARENT_COLOR where nothing is drawn
module bird_bitmap import bird_pkg::*; #(
  parameter int OBJ_W = 32,
  parameter int OBJ_H = 32
) (
  input  logic                     frame,
  input  logic [$clog2(OBJ_H)-1:0] off_y,
  input  logic [$clog2(OBJ_W)-1:0] off_x,
  output logic [7:0]               color
);

  localparam int YW = $clog2(OBJ_H);
  localparam int XW = $clog2(OBJ_W);

  localparam logic [YW-1:0] ROW_TOP  = YW'(OBJ_H / 8);
  localparam logic [YW-1:0] ROW_BOT  = YW'(OBJ_H - OBJ_H / 8);
  localparam logic [YW-1:0] CORNER_Y = YW'(OBJ_H / 4);
  localparam logic [YW-1:0] WING_Y   = YW'((3 * OBJ_H) / 8);
  localparam logic [YW-1:0] EYE_Y    = YW'((5 * OBJ_H) / 16);

  localparam logic [XW-1:0] CORNER_X = XW'(OBJ_W / 16);
  localparam logic [XW-1:0] WING_X0  = XW'(OBJ_W / 4);
  localparam logic [XW-1:0] WING_X1  = XW'(OBJ_W / 2);
  localparam logic [XW-1:0] EYE_X    = XW'((3 * OBJ_W) / 4);

  always_comb begin
    color = BODY_COLOR;
    if (off_y < ROW_TOP || off_y >= ROW_BOT) begin
      color = TRANSPARENT_COLOR;
    end else if (off_x < CORNER_X && off_y < CORNER_Y) begin
      color = TRANSPARENT_COLOR;
    end else if (off_y < WING_Y && off_x >= WING_X0 && off_x < WING_X1) begin
      color = frame ? WING_UP_COLOR : WING_DN_COLOR;
    end else if (off_y == EYE_Y && off_x == EYE_X) begin
      color = EYE_COLOR;
    end
  end

endmodule

// File: rtl/bird_object.sv
// Per-bird object stage: owns position, motion and hit/fall/respawn life
// cycle, picks the flap frame and hit-tests the VGA scan position. The
// drawing request and colour are registered, one cycle after pixelX/Y.
// Ports:
//   clk, resetN         : pixel clock, async active-low reset
//   enable              : bird active while high
//   startOfFrame        : one-cycle pulse per VGA frame
//   pixelX, pixelY      : current scan position
//   collision           : bird overlaps a shot this cycle
//   birdDrawingRequest  : opaque bird pixel at previous scan position
//   birdRGB             : colour for that pixel (FF when not drawn)
//   birdHit             : pulse on the FLYING->HIT transition
//   topLeftX, topLeftY  : current signed position
module bird_object import bird_pkg::*; #(
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 64,
  parameter int SPEED_X     = 2,
  parameter int FALL_SPEED  = 4,
  parameter int HIT_FRAMES  = 30,
  parameter int FLAP_FRAMES = 8,
  parameter int OBJ_W       = 32,
  parameter int OBJ_H       = 32,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      enable,
  input  logic                      startOfFrame,
  input  logic [10:0]               pixelX,
  input  logic [10:0]               pixelY,
  input  logic                      collision,
  output logic                      birdDrawingRequest,
  output logic [7:0]                birdRGB,
  output logic                      birdHit,
  output logic signed [COORD_W-1:0] topLeftX,
  output logic signed [COORD_W-1:0] topLeftY
);

  localparam coord_t INIT_X_C   = coord_t'(INIT_X);
  localparam coord_t INIT_Y_C   = coord_t'(INIT_Y);
  localparam coord_t SPEED_C    = coord_t'(SPEED_X);
  localparam coord_t FALL_C     = coord_t'(FALL_SPEED);
  localparam coord_t OBJ_W_C    = coord_t'(OBJ_W);
  localparam coord_t OBJ_H_C    = coord_t'(OBJ_H);
  localparam coord_t SCREEN_W_C = coord_t'(SCREEN_W);
  localparam coord_t SCREEN_H_C = coord_t'(SCREEN_H);
  localparam coord_t WRAP_X_C   = coord_t'(-OBJ_W);

  localparam int XW = $clog2(OBJ_W);
  localparam int YW = $clog2(OBJ_H);

  localparam int HIT_CW  = (HIT_FRAMES  > 1) ? $clog2(HIT_FRAMES)  : 1;
  localparam int FLAP_CW = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;
  localparam logic [HIT_CW-1:0]  HIT_LAST  = HIT_CW'(HIT_FRAMES - 1);
  localparam logic [FLAP_CW-1:0] FLAP_LAST = FLAP_CW'(FLAP_FRAMES - 1);

  bird_state_e         state, state_n;
  coord_t              x, x_n, y, y_n;
  logic [HIT_CW-1:0]   hit_cnt, hit_cnt_n;
  logic [FLAP_CW-1:0]  flap_cnt, flap_cnt_n;
  logic                anim_frame, anim_n;
  logic                hit_n;

  coord_t              x_adv, x_step;

  // Horizontal step with wrap: only wrap once strictly past the right edge
  always_comb begin
    x_adv  = x + SPEED_C;
    x_step = (x_adv > SCREEN_W_C) ? WRAP_X_C : x_adv;
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      x          <= INIT_X_C;
      y          <= INIT_Y_C;
      hit_cnt    <= '0;
      flap_cnt   <= '0;
      anim_frame <= 1'b0;
      birdHit    <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      hit_cnt    <= hit_cnt_n;
      flap_cnt   <= flap_cnt_n;
      anim_frame <= anim_n;
      birdHit    <= hit_n;
    end
  end

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    hit_cnt_n  = hit_cnt;
    flap_cnt_n = flap_cnt;
    anim_n     = anim_frame;
    hit_n      = 1'b0;

    if (!enable) begin
      state_n    = IDLE;
      x_n        = INIT_X_C;
      y_n        = INIT_Y_C;
      hit_cnt_n  = '0;
      flap_cnt_n = '0;
      anim_n     = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = FLYING;

        FLYING: begin
          // A collision wins over a coincident frame tick: no motion then
          if (collision) begin
            state_n   = HIT;
            hit_n     = 1'b1;
            hit_cnt_n = '0;
          end else if (startOfFrame) begin
            x_n = x_step;
            if (flap_cnt == FLAP_LAST) begin
              flap_cnt_n = '0;
              anim_n     = ~anim_frame;
            end else begin
              flap_cnt_n = flap_cnt + 1'b1;
            end
          end
        end

        HIT: begin
          if (startOfFrame) begin
            if (hit_cnt == HIT_LAST) begin
              state_n   = FALLING;
              hit_cnt_n = '0;
            end else begin
              hit_cnt_n = hit_cnt + 1'b1;
            end
          end
        end

        FALLING: begin
          // Bottom test is on the registered Y, so the bird sits at the
          // landing row for one cycle before respawning
          if (y >= SCREEN_H_C) begin
            state_n = RESPAWN;
          end else if (startOfFrame) begin
            y_n = y + FALL_C;
          end
        end

        RESPAWN: begin
          state_n    = FLYING;
          x_n        = INIT_X_C;
          y_n        = INIT_Y_C;
          hit_cnt_n  = '0;
          flap_cnt_n = '0;
          anim_n     = 1'b0;
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ drawing
  coord_t          px, py, x_end, y_end;
  logic            in_box;
  logic [XW-1:0]   off_x;
  logic [YW-1:0]   off_y;
  logic [7:0]      rom_color;
  logic            pix_opaque;
  logic [7:0]      pix_color;

  always_comb begin
    px     = to_coord(pixelX);
    py     = to_coord(pixelY);
    x_end  = x + OBJ_W_C;
    y_end  = y + OBJ_H_C;
    in_box = (px >= x) && (px < x_end) && (py >= y) && (py < y_end);
    // Truncated offsets are only meaningful when in_box is true, which
    // keeps the image from wrapping across the screen edge
    off_x  = XW'(px - x);
    off_y  = YW'(py - y);
  end

  bird_bitmap #(
    .OBJ_W (OBJ_W),
    .OBJ_H (OBJ_H)
  ) u_bitmap (
    .frame (anim_frame),
    .off_y (off_y),
    .off_x (off_x),
    .color (rom_color)
  );

  always_comb begin
    pix_opaque = in_box && (state != IDLE) && (rom_color != TRANSPARENT_COLOR);
    pix_color  = (state == HIT) ? HIT_COLOR : rom_color;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      birdDrawingRequest <= 1'b0;
      birdRGB            <= 8'h00;
    end else begin
      birdDrawingRequest <= pix_opaque;
      birdRGB            <= pix_opaque ? pix_color : TRANSPARENT_COLOR;
    end
  end

  assign topLeftX = x;
  assign topLeftY = y;

endmodule

// File: doc/bird_object.md
Name: bird_object

Overview:
- Per-bird object stage that feeds one input pair of the birds priority mux (birdNDrawingRequest / birdNRGB).
- Owns the bird's screen position, its per-frame motion and its hit/fall/respawn life cycle.
- Selects the wing-flap animation frame.
- Performs the pixel hit-test against the VGA scan position, producing a registered drawing request and 8-bit RGB one cycle after the pixel coordinates.

Parameters:
- INIT_X, 0, respawn top-left X in pixels (signed 12-bit).
- INIT_Y, 64, respawn top-left Y in pixels (signed 12-bit).
- SPEED_X, 2, pixels added to X per frame while FLYING.
- FALL_SPEED, 4, pixels added to Y per frame while FALLING.
- HIT_FRAMES, 30, frames the bird freezes after a hit.
- FLAP_FRAMES, 8, frames per animation frame toggle.
- OBJ_W, 32, bird width in pixels.
- OBJ_H, 32, bird height in pixels.
- SCREEN_W, 640, visible width.
- SCREEN_H, 480, visible height.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- enable  in  1  level; bird is active while high.
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- pixelX  in  11  current scan X.
- pixelY  in  11  current scan Y.
- collision  in  1  pulse; bird overlaps a shot this cycle.
- birdDrawingRequest  out  1  registered; bird pixel is opaque at the previous-cycle pixelX/Y.
- birdRGB  out  8  registered RRRGGGBB colour.
- birdHit  out  1  one-cycle pulse on the FLYING->HIT transition.
- topLeftX  out  12  signed current X.
- topLeftY  out  12  signed current Y.

Behaviour:
Clock and reset:
- One clock, clk. Reset is resetN, asynchronous, active-low.
- Reset values: state=IDLE, topLeftX=INIT_X, topLeftY=INIT_Y, frame counters=0, animFrame=0, birdDrawingRequest=0, birdRGB=8'h00, birdHit=0.

States:
- IDLE: not drawn. Go to FLYING on the first cycle enable=1.
- FLYING:
  - On startOfFrame: X += SPEED_X.
  - If the new X > SCREEN_W (signed compare), X wraps to -OBJ_W.
  - collision=1 -> HIT next cycle and birdHit=1 for exactly that cycle.
  - collision takes priority over a coincident startOfFrame; no motion in that cycle.
- HIT:
  - Position frozen; animFrame frozen.
  - Count startOfFrame pulses; after HIT_FRAMES pulses go to FALLING.
- FALLING:
  - On startOfFrame: Y += FALL_SPEED.
  - When Y >= SCREEN_H go to RESPAWN.
- RESPAWN: one cycle. Load INIT_X/INIT_Y, clear counters, go to FLYING.
- enable=0 in any state: next cycle forces IDLE and reloads INIT_X/INIT_Y.
- collision outside FLYING is ignored; birdHit is never asserted outside the FLYING->HIT transition.

Animation:
- flap counter counts startOfFrame pulses in FLYING.
- Every FLAP_FRAMES pulses, animFrame toggles and the counter clears.

Drawing (1-cycle latency):
- inside = (pixelX >= X) && (pixelX < X+OBJ_W) && (pixelY >= Y) && (pixelY < Y+OBJ_H). All comparisons are 12-bit signed, with pixelX/Y zero-extended.
- offsetX = pixelX - X and offsetY = pixelY - Y, both truncated to log2(OBJ_W) and log2(OBJ_H) bits.
- Bitmap lookup by {animFrame, offsetY, offsetX}.
- Next cycle:
  - birdDrawingRequest = inside && state != IDLE && colour != TRANSPARENT (8'hFF).
  - birdRGB = colour when the request is 1, else 8'hFF.
- In HIT the colour is replaced by HIT_COLOR (8'hE0) for opaque pixels.
- Partially off-screen positions (negative X after wrap) draw only the visible part. No wrap of the image across the edge.

Decomposition:
- Package bird_pkg:
  - state enum {IDLE, FLYING, HIT, FALLING, RESPAWN}.
  - TRANSPARENT_COLOR = 8'hFF, HIT_COLOR = 8'hE0.
  - coordinate width constant (12).
- Sub-module bird_bitmap: combinational ROM, 2 frames x OBJ_H x OBJ_W x 8 bits, addressed by animFrame/offsetY/offsetX.

Test Plan:
- Reset release with enable=1, 3 startOfFrame pulses -> state FLYING, topLeftX = INIT_X+6 = 6, birdHit never asserted.
- X=638, SPEED_X=2, then startOfFrame -> X=640 (no wrap, not > SCREEN_W); next startOfFrame -> X=-32. Pixel (0, INIT_Y) maps to offsetX=32-bit-truncated value, drawn only if X+OBJ_W > 0.
- Pixel scan across bird at X=100, Y=64 -> request asserted one cycle after pixelX=100 (opaque pixel), deasserted one cycle after pixelX=132. Request is 0 wherever the bitmap value is 8'hFF.
- collision and startOfFrame in the same cycle -> birdHit=1 for one cycle, X unchanged. Then 30 startOfFrame pulses -> FALLING, with opaque pixels drawn as 8'hE0 during HIT.
- FALLING from Y=464 -> after 4 frames Y=480 -> RESPAWN -> FLYING at (INIT_X, INIT_Y). A collision pulse during FALLING produces no birdHit.
- enable dropped mid-FALLING, or resetN asserted mid-frame -> next cycle/immediately IDLE with request=0 and position=(INIT_X, INIT_Y). Under reset, birdRGB=8'h00.
